// File: rtl/clock_pkg.sv
// Shared types and constants for the HH:MM:SS time-of-day core:
// mode states, field limits and the per-state HEX digit edit masks.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_e;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  // Bit n corresponds to HEXn (HEX0 = seconds ones ... HEX5 = hours tens).
  localparam logic [5:0] MASK_RUN = 6'b000000;
  localparam logic [5:0] MASK_SEC = 6'b000011;
  localparam logic [5:0] MASK_MIN = 6'b001100;
  localparam logic [5:0] MASK_HR  = 6'b110000;

  function automatic logic [5:0] mask_of(input state_e s);
    case (s)
      SET_HR:  return MASK_HR;
      SET_MIN: return MASK_MIN;
      SET_SEC: return MASK_SEC;
      default: return MASK_RUN;
    endcase
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping over 00..MAX. Counts up on inc or carry-in,
// down on dec; wrap flags the carry-in that rolls MAX over to 00.
module bcd_mod_counter #(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       cin,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       wrap
);

  localparam logic [3:0] MAX_TENS = 4'(MAX / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX % 10);

  logic up, at_max, at_zero;

  assign up      = inc | cin;
  assign at_max  = (tens == MAX_TENS) && (ones == MAX_ONES);
  assign at_zero = (tens == 4'd0) && (ones == 4'd0);
  assign wrap    = cin & at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (up && !dec) begin
      if (at_max) begin
        ones <= 4'd0;
        tens <= 4'd0;
      end else if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end else if (dec && !up) begin
      if (at_zero) begin
        ones <= MAX_ONES;
        tens <= MAX_TENS;
      end else if (ones == 4'd0) begin
        ones <= 4'd9;
        tens <= tens - 4'd1;
      end else begin
        ones <= ones - 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_of_day_core.sv
// 24-hour BCD time-of-day core: prescaler to a 1 Hz tick, sec/min/hr carry
// chain, and a button-driven set mode editing one field at a time.
module time_of_day_core
  import clock_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_mode,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [3:0] o_sec_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_hr_ones,
  output logic [3:0] o_hr_tens,
  output logic       o_tick,
  output logic [5:0] o_edit_mask
);

  localparam int PW = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLOCK_FREQ - 1);

  state_e        state;
  logic [PW-1:0] presc;
  logic          tick_now;
  logic          edit_ok;
  logic          sec_inc, sec_dec, min_inc, min_dec, hr_inc, hr_dec;
  logic          sec_wrap, min_wrap, hr_wrap_unused;

  assign tick_now = (state == RUN) && (presc == PRE_LAST);

  // A mode pulse wins over any inc/dec arriving in the same cycle.
  assign edit_ok = !i_mode && (i_inc ^ i_dec);
  assign sec_inc = edit_ok && i_inc && (state == SET_SEC);
  assign sec_dec = edit_ok && i_dec && (state == SET_SEC);
  assign min_inc = edit_ok && i_inc && (state == SET_MIN);
  assign min_dec = edit_ok && i_dec && (state == SET_MIN);
  assign hr_inc  = edit_ok && i_inc && (state == SET_HR);
  assign hr_dec  = edit_ok && i_dec && (state == SET_HR);

  // Held at 0 outside RUN so the first tick after leaving set mode is a full period away.
  always_ff @(posedge clk) begin
    if (rst || state != RUN || presc == PRE_LAST) presc <= '0;
    else                                         presc <= presc + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) o_tick <= 1'b0;
    else     o_tick <= tick_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      o_edit_mask <= MASK_RUN;
    end else if (i_mode) begin
      case (state)
        RUN:     begin state <= SET_HR;  o_edit_mask <= mask_of(SET_HR);  end
        SET_HR:  begin state <= SET_MIN; o_edit_mask <= mask_of(SET_MIN); end
        SET_MIN: begin state <= SET_SEC; o_edit_mask <= mask_of(SET_SEC); end
        default: begin state <= RUN;     o_edit_mask <= mask_of(RUN);     end
      endcase
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk (clk),
    .rst (rst),
    .inc (sec_inc),
    .dec (sec_dec),
    .cin (tick_now),
    .ones(o_sec_ones),
    .tens(o_sec_tens),
    .wrap(sec_wrap)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk (clk),
    .rst (rst),
    .inc (min_inc),
    .dec (min_dec),
    .cin (sec_wrap),
    .ones(o_min_ones),
    .tens(o_min_tens),
    .wrap(min_wrap)
  );

  bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
    .clk (clk),
    .rst (rst),
    .inc (hr_inc),
    .dec (hr_dec),
    .cin (min_wrap),
    .ones(o_hr_ones),
    .tens(o_hr_tens),
    .wrap(hr_wrap_unused)
  );

endmodule

// File: tb/tb_time_of_day_core.sv
// Directed bench for time_of_day_core at CLOCK_FREQ = 4; expected values are
// hand-computed BCD times (24'hHHMMSS), masks and tick positions.
module tb_time_of_day_core;

  logic       clk = 1'b0;
  logic       rst, i_mode, i_inc, i_dec;
  logic [3:0] o_sec_ones, o_sec_tens, o_min_ones, o_min_tens, o_hr_ones, o_hr_tens;
  logic       o_tick;
  logic [5:0] o_edit_mask;
  int         checks = 0;
  int         errors = 0;
  int         ticks;

  time_of_day_core #(.CLOCK_FREQ(4)) dut (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_inc(i_inc), .i_dec(i_dec),
    .o_sec_ones(o_sec_ones), .o_sec_tens(o_sec_tens),
    .o_min_ones(o_min_ones), .o_min_tens(o_min_tens),
    .o_hr_ones(o_hr_ones), .o_hr_tens(o_hr_tens),
    .o_tick(o_tick), .o_edit_mask(o_edit_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] hms();
    return {o_hr_tens, o_hr_ones, o_min_tens, o_min_ones, o_sec_tens, o_sec_ones};
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic m, input logic a, input logic d);
    i_mode = m; i_inc = a; i_dec = d;
    @(posedge clk); #1;
    i_mode = 1'b0; i_inc = 1'b0; i_dec = 1'b0;
  endtask

  task automatic repeat_step(input int n, input logic a, input logic d);
    for (int i = 0; i < n; i++) step(1'b0, a, d);
  endtask

  initial begin
    rst = 1'b1; i_mode = 1'b0; i_inc = 1'b0; i_dec = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_time", hms(), 24'h000000);
    chk("reset_tick", {23'd0, o_tick}, 24'd0);
    chk("reset_mask", {18'd0, o_edit_mask}, 24'd0);
    rst = 1'b0;

    // Free run: ticks on every 4th edge.
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("run_tick_%0d", i), {23'd0, o_tick}, {23'd0, (i % 4 == 0)});
    end
    chk("run_time_3s", hms(), 24'h000003);

    // Set 23:59:58: hr dec wrap, min dec wrap, sec down.
    step(1'b1, 1'b0, 1'b0);
    chk("mask_set_hr", {18'd0, o_edit_mask}, {18'd0, 6'b110000});
    step(1'b0, 1'b0, 1'b1);
    chk("hr_dec_wrap", hms(), 24'h230003);
    chk("hr_dec_mask", {18'd0, o_edit_mask}, {18'd0, 6'b110000});
    step(1'b1, 1'b0, 1'b0);
    chk("mask_set_min", {18'd0, o_edit_mask}, {18'd0, 6'b001100});
    step(1'b0, 1'b0, 1'b1);
    chk("min_dec_wrap", hms(), 24'h235903);
    step(1'b1, 1'b0, 1'b0);
    chk("mask_set_sec", {18'd0, o_edit_mask}, {18'd0, 6'b000011});
    repeat_step(5, 1'b0, 1'b1);
    chk("sec_set_58", hms(), 24'h235958);
    step(1'b0, 1'b1, 1'b1);
    chk("inc_dec_together", hms(), 24'h235958);
    step(1'b1, 1'b0, 1'b0);
    chk("mask_run", {18'd0, o_edit_mask}, 24'd0);

    // Two ticks: 23:59:59 then full rollover in one edge.
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("roll_tick_%0d", i), {23'd0, o_tick}, {23'd0, (i % 4 == 0)});
      if (i == 4) chk("roll_235959", hms(), 24'h235959);
      if (i == 7) chk("roll_hold", hms(), 24'h235959);
    end
    chk("roll_000000", hms(), 24'h000000);

    // Enter set mode mid-count; prescaler must hold.
    repeat_step(2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (o_tick) ticks++;
    end
    chk("hold_no_tick", 24'(ticks), 24'd0);
    chk("hold_time", hms(), 24'h000000);

    // Priority: mode + inc in SET_MIN at 10.
    step(1'b1, 1'b0, 1'b0);
    repeat_step(10, 1'b1, 1'b0);
    chk("min_at_10", hms(), 24'h001000);
    step(1'b1, 1'b1, 1'b0);
    chk("prio_mask", {18'd0, o_edit_mask}, {18'd0, 6'b000011});
    chk("prio_min", hms(), 24'h001000);

    // Restart: first tick exactly 4 cycles after leaving SET_SEC.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("restart_tick_%0d", i), {23'd0, o_tick}, {23'd0, (i == 4)});
    end
    chk("restart_time", hms(), 24'h001001);

    // Build 12:34:56 (with hr inc wrap), then reset while in SET_MIN.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk("hr_inc_wrap", hms(), 24'h001001);
    repeat_step(12, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat_step(24, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat_step(5, 1'b0, 1'b1);
    chk("set_123456", hms(), 24'h123456);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("midedit_mask", {18'd0, o_edit_mask}, {18'd0, 6'b001100});
    chk("midedit_time", hms(), 24'h123456);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_time", hms(), 24'h000000);
    chk("rst_mid_mask", {18'd0, o_edit_mask}, 24'd0);
    chk("rst_mid_tick", {23'd0, o_tick}, 24'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_state_run", {18'd0, o_edit_mask}, {18'd0, 6'b110000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_of_day_core.md
# time_of_day_core

- Time-keeping stage directly upstream of the seven-segment display decoders in the MAX-10 digital clock.
- Divides the board clock down to a 1 Hz tick and maintains a 24-hour HH:MM:SS count as six BCD digits.
- Provides a button-driven set mode in which the hours, minutes and seconds fields are edited in turn.
- Its digit outputs feed the per-digit HEX0..HEX5 encoders one-to-one: HEX0 = seconds ones … HEX5 = hours tens.

## Interface
- CLOCK_FREQ, 50_000_000 — clk frequency in Hz; prescaler period in cycles; legal range ≥ 1
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- i_mode  in  1  one-cycle pulse (debounced upstream); advances the mode state machine
- i_inc  in  1  one-cycle pulse; increments the selected field in set states
- i_dec  in  1  one-cycle pulse; decrements the selected field in set states
- o_sec_ones, o_sec_tens  out  4 each  seconds BCD digits
- o_min_ones, o_min_tens  out  4 each  minutes BCD digits
- o_hr_ones, o_hr_tens  out  4 each  hours BCD digits
- o_tick  out  1  one-cycle pulse coincident with every seconds advance in RUN
- o_edit_mask  out  6  bit n set = HEXn digit is under edit; bit order matches HEX0..HEX5

## Operation
- States and transitions:
  - RUN → SET_HR → SET_MIN → SET_SEC → RUN, each transition on one i_mode pulse.
  - No other transitions exist.
- RUN behaviour:
  - Prescaler counts 0..CLOCK_FREQ-1, then wraps to 0.
  - On the cycle the prescaler equals CLOCK_FREQ-1, seconds advance by one.
  - Carry chain: sec 59→00 carries into min; min 59→00 carries into hr; hr 23→00 with no further carry.
  - 23:59:59 advances to 00:00:00 in a single edge.
- Set states:
  - Prescaler is held at 0 and no tick occurs.
  - i_inc/i_dec modify only the selected field, wrapping within that field: sec/min 00..59, hr 00..23.
  - Inc 59→00, dec 00→59, hr inc 23→00, hr dec 00→23.
  - No carry into neighbouring fields.
- Leaving SET_SEC → RUN restarts the prescaler from 0, so the first tick arrives CLOCK_FREQ cycles later.
- o_edit_mask values:
  - RUN: 000000
  - SET_SEC: 000011
  - SET_MIN: 001100
  - SET_HR: 110000
- Priority / simultaneous events:
  - i_mode pulse and i_inc/i_dec in the same cycle: only the mode transition takes effect; inc/dec is dropped.
  - i_inc and i_dec in the same cycle: no change.
  - i_inc/i_dec in RUN: ignored.
- Arithmetic: each field is kept as two 4-bit BCD digits and never holds a non-BCD or out-of-range value.

## Timing
- Reset values:
  - All digits 0, state RUN, prescaler 0, o_tick 0, o_edit_mask 000000.
  - rst asserted mid-operation (any state) takes effect at the next edge, with the same values.
- All outputs are registered; no combinational path from inputs to outputs.
- o_tick is high exactly one cycle, in the same cycle the new digit values first appear.
- Tick spacing in RUN is exactly CLOCK_FREQ cycles.
- CLOCK_FREQ = 1 gives a tick every cycle.
- Latency:
  - An inc/dec pulse at edge k changes the digits visible after edge k.
  - An i_mode pulse at edge k changes o_edit_mask visible after edge k.

## Structure
- Shared package clock_pkg holds:
  - State enum: RUN, SET_HR, SET_MIN, SET_SEC
  - Field limit constants: SEC_MAX = 59, MIN_MAX = 59, HR_MAX = 23
  - Edit-mask constants
- Sub-module bcd_mod_counter:
  - Parameter: MAX (two-digit BCD limit)
  - Inputs: clk, rst, inc, dec, carry-in enable
  - Outputs: ones, tens, wrap flag
  - Instantiated three times (sec, min, hr).
- Top level holds the prescaler, the mode FSM and the inc/dec/tick steering into the three counters.

## Test plan
- Reset and count (CLOCK_FREQ = 4):
  - Stimulus: rst for 2 cycles, then run 12 cycles.
  - Required: digits 00:00:00 during reset; o_tick pulses every 4th cycle; display reaches 00:00:03.
- Full rollover:
  - Stimulus: set time to 23:59:58 via set mode, return to RUN, wait 2 ticks.
  - Required: 23:59:59, then 00:00:00 with a single o_tick on the wrap cycle.
- Set-mode wrap:
  - Stimulus: in SET_HR at 00, one i_dec pulse.
  - Required: hr = 23; min/sec unchanged; o_edit_mask = 110000.
- Priority:
  - Stimulus: i_mode and i_inc in the same cycle in SET_MIN at 10.
  - Required: state becomes SET_SEC; min stays 10.
  - Stimulus: i_inc and i_dec together in SET_SEC.
  - Required: no change.
- Prescaler hold and restart:
  - Stimulus: enter SET_HR mid-count and wait 20 cycles.
  - Required: no o_tick.
  - Stimulus: exit to RUN.
  - Required: first o_tick exactly 4 cycles later.
- Reset mid-edit:
  - Stimulus: assert rst in SET_MIN with time 12:34:56.
  - Required: next edge gives 00:00:00, RUN, o_edit_mask 000000.
